// File: rtl/l0mdt_dataformats_svh.sv
// Shared L0MDT data-format constants; the MTC scheduler and the SL transmitter
// both size themselves from here.
package l0mdt_dataformats_svh;

    localparam int MTC2SL_LEN      = 64;
    localparam int MTC_SCHED_N_IN  = 3;
    localparam int MTC_SCHED_DEPTH = 4;

endpackage

// File: rtl/mtc_sched_fifo.sv
// Per-formatter packet FIFO. Storage is registered and read data is shown ahead,
// so the head packet is visible as soon as the FIFO is non-empty.
module mtc_sched_fifo
    import l0mdt_dataformats_svh::*;
#(
    parameter int WIDTH = MTC2SL_LEN,
    parameter int DEPTH = MTC_SCHED_DEPTH
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mtc_out_sched.sv
// MTC output scheduler: per-formatter FIFOs, round-robin arbitration onto one
// valid/ready link, and saturating per-input drop statistics.
module mtc_out_sched
    import l0mdt_dataformats_svh::*;
#(
    parameter int N_IN          = MTC_SCHED_N_IN,
    parameter int DEPTH         = MTC_SCHED_DEPTH,
    parameter int MTC_PKT_WIDTH = MTC2SL_LEN,
    parameter int CNT_WIDTH     = 16,
    parameter int SRC_W         = $clog2(N_IN)
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic [N_IN*MTC_PKT_WIDTH-1:0] in_mtc,
    input  logic [N_IN-1:0]               in_valid,
    output logic [MTC_PKT_WIDTH-1:0]      out_mtc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SRC_W-1:0]              out_src,
    input  logic                          clr_stats,
    output logic [N_IN*CNT_WIDTH-1:0]     drop_cnt,
    output logic [N_IN-1:0]               overflow,
    output logic [N_IN-1:0]               fifo_empty
);

    logic [MTC_PKT_WIDTH-1:0] fifo_data [N_IN];
    logic [N_IN-1:0]          full;
    logic [N_IN-1:0]          empty_v;
    logic [N_IN-1:0]          pop;
    logic [N_IN-1:0]          drop;
    logic [CNT_WIDTH-1:0]     cnt_q [N_IN];
    logic                     ovf_q [N_IN];

    logic [SRC_W-1:0]         last_grant;
    logic [SRC_W:0]           pick;
    logic [SRC_W-1:0]         grant;
    logic                     found;
    logic                     load;

    logic [MTC_PKT_WIDTH-1:0] mtc_p1;
    logic [SRC_W-1:0]         src_p1;
    logic                     vld_p1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    // Returns {found, index}: first non-empty FIFO after last, wrapping modulo N_IN.
    function automatic logic [SRC_W:0] rr_pick(input logic [N_IN-1:0] empty,
                                               input logic [SRC_W-1:0] last);
        logic [SRC_W:0]   r;
        logic [SRC_W-1:0] idx;
        r = '0;
        for (int k = N_IN; k >= 1; k--) begin
            idx = SRC_W'((int'(last) + k) % N_IN);
            if (!empty[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    always_comb begin
        pick  = rr_pick(empty_v, last_grant);
        grant = pick[SRC_W-1:0];
        found = pick[SRC_W];
        load  = found && (!vld_p1 || out_ready);
        pop   = '0;
        if (load) pop[grant] = 1'b1;
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        mtc_sched_fifo #(
            .WIDTH (MTC_PKT_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock (clock),
            .rst_n (rst_n),
            .push  (in_valid[i]),
            .pop   (pop[i]),
            .wdata (in_mtc[i*MTC_PKT_WIDTH +: MTC_PKT_WIDTH]),
            .rdata (fifo_data[i]),
            .full  (full[i]),
            .empty (empty_v[i])
        );

        assign drop[i] = in_valid[i] && full[i] && !pop[i];

        // Clear takes priority over a drop landing in the same cycle.
        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[i] <= '0;
                ovf_q[i] <= 1'b0;
            end else if (clr_stats) begin
                cnt_q[i] <= '0;
                ovf_q[i] <= 1'b0;
            end else if (drop[i]) begin
                cnt_q[i] <= sat_inc(cnt_q[i]);
                ovf_q[i] <= 1'b1;
            end
        end

        assign drop_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        assign overflow[i]                        = ovf_q[i];
    end

    // p1: output register, also the point where the round-robin pointer advances
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mtc_p1     <= '0;
            src_p1     <= '0;
            vld_p1     <= 1'b0;
            last_grant <= SRC_W'(N_IN - 1);
        end else if (load) begin
            mtc_p1     <= fifo_data[grant];
            src_p1     <= grant;
            vld_p1     <= 1'b1;
            last_grant <= grant;
        end else if (out_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    assign out_mtc    = mtc_p1;
    assign out_src    = src_p1;
    assign out_valid  = vld_p1;
    assign fifo_empty = empty_v;

endmodule

// File: tb/tb_mtc_out_sched.sv
// Bench for mtc_out_sched: hand-derived vector table plus a queue-based
// scoreboard that tracks what each FIFO and the output register should hold.
module tb_mtc_out_sched;
    import l0mdt_dataformats_svh::*;

    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int W     = MTC2SL_LEN;
    localparam int CW    = 16;

    logic             clock;
    logic             rst_n;
    logic [N*W-1:0]   in_mtc;
    logic [N-1:0]     in_valid;
    logic [W-1:0]     out_mtc;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_src;
    logic             clr_stats;
    logic [N*CW-1:0]  drop_cnt;
    logic [N-1:0]     overflow;
    logic [N-1:0]     fifo_empty;

    mtc_out_sched #(
        .N_IN          (N),
        .DEPTH         (DEPTH),
        .MTC_PKT_WIDTH (W),
        .CNT_WIDTH     (CW)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .in_mtc     (in_mtc),
        .in_valid   (in_valid),
        .out_mtc    (out_mtc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .clr_stats  (clr_stats),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow),
        .fifo_empty (fifo_empty)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total  = 0;
    int passed = 0;
    int seq    = 0;
    bit force_a5 = 1'b0;

    // Scoreboard / reference state
    logic [W-1:0] mq [N][$];
    logic         mvld;
    logic [W-1:0] mdata;
    int           msrc;
    int           mlast;
    int           mcnt [N];
    logic         movf [N];

    typedef struct {
        logic [2:0] vin;
        logic       rdy;
        logic       exp_vld;
        logic [1:0] exp_src;
        logic [2:0] exp_empty;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic logic [W-1:0] mkdata(input int i, input int s);
        return W'({8'(8'hD0 + i), 24'h0, 32'(s)});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            mcnt[i] = 0;
            movf[i] = 1'b0;
        end
        mvld  = 1'b0;
        mdata = '0;
        msrc  = 0;
        mlast = N - 1;
    endtask

    task automatic model_edge(input logic [2:0] vin, input logic rdy, input logic clr,
                              input logic [N*W-1:0] d);
        int  g;
        bit  fnd;
        fnd = 1'b0;
        g   = 0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (mlast + k) % N;
            if (!fnd && mq[idx].size() != 0) begin
                fnd = 1'b1;
                g   = idx;
            end
        end
        if (fnd && (!mvld || rdy)) begin
            mdata = mq[g].pop_front();
            msrc  = g;
            mvld  = 1'b1;
            mlast = g;
        end else if (rdy) begin
            mvld = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (vin[i]) begin
                if (mq[i].size() < DEPTH) begin
                    mq[i].push_back(d[i*W +: W]);
                end else if (!clr) begin
                    if (mcnt[i] < 65535) mcnt[i]++;
                    movf[i] = 1'b1;
                end
            end
        end
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                mcnt[i] = 0;
                movf[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        logic [N*CW-1:0] ecnt;
        logic [N-1:0]    eovf;
        logic [N-1:0]    eemp;
        for (int i = 0; i < N; i++) begin
            ecnt[i*CW +: CW] = CW'(mcnt[i]);
            eovf[i]          = movf[i];
            eemp[i]          = (mq[i].size() == 0);
        end
        check("out_valid", 64'(out_valid), 64'(mvld));
        if (mvld) begin
            check("out_mtc", 64'(out_mtc), 64'(mdata));
            check("out_src", 64'(out_src), 64'(msrc));
        end
        check("fifo_empty", 64'(fifo_empty), 64'(eemp));
        check("drop_cnt", 64'(drop_cnt), 64'(ecnt));
        check("overflow", 64'(overflow), 64'(eovf));
    endtask

    // Called at a negedge: drive one cycle of stimulus, advance the model, compare.
    task automatic step(input logic [2:0] vin, input logic rdy, input logic clr, input bit chk);
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) begin
            d[i*W +: W] = force_a5 ? {(W/8){8'hA5}} : mkdata(i, seq);
        end
        seq++;
        in_mtc    = d;
        in_valid  = vin;
        out_ready = rdy;
        clr_stats = clr;
        model_edge(vin, rdy, clr, d);
        @(posedge clock);
        @(negedge clock);
        in_valid  = '0;
        clr_stats = 1'b0;
        if (chk) compare_all();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_mtc    = '0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        model_reset();
    endtask

    int           cnt;
    logic [W-1:0] held;

    initial begin
        tbl[0]  = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000};
        tbl[1]  = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b000};
        tbl[2]  = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b000};
        tbl[3]  = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b000};
        tbl[4]  = '{3'b000, 1'b1, 1'b1, 2'd0, 3'b000};
        tbl[5]  = '{3'b000, 1'b1, 1'b1, 2'd1, 3'b000};
        tbl[6]  = '{3'b000, 1'b1, 1'b1, 2'd2, 3'b000};
        tbl[7]  = '{3'b000, 1'b1, 1'b1, 2'd0, 3'b000};
        tbl[8]  = '{3'b000, 1'b1, 1'b1, 2'd1, 3'b000};
        tbl[9]  = '{3'b000, 1'b1, 1'b1, 2'd2, 3'b000};
        tbl[10] = '{3'b000, 1'b1, 1'b1, 2'd0, 3'b001};
        tbl[11] = '{3'b000, 1'b1, 1'b1, 2'd1, 3'b011};
        tbl[12] = '{3'b000, 1'b1, 1'b1, 2'd2, 3'b111};
        tbl[13] = '{3'b000, 1'b1, 1'b0, 2'd0, 3'b111};

        // Reset state
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_mtc", 64'(out_mtc), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_fifo_empty", 64'(fifo_empty), 64'b111);

        // Fairness: hand-derived round-robin sequence
        for (int v = 0; v < 14; v++) begin
            step(tbl[v].vin, tbl[v].rdy, 1'b0, 1'b1);
            check($sformatf("tbl%0d_valid", v), 64'(out_valid), 64'(tbl[v].exp_vld));
            if (tbl[v].exp_vld)
                check($sformatf("tbl%0d_src", v), 64'(out_src), 64'(tbl[v].exp_src));
            check($sformatf("tbl%0d_empty", v), 64'(fifo_empty), 64'(tbl[v].exp_empty));
        end
        check("fair_drops", 64'(drop_cnt), 64'd0);

        // Single packet latency
        do_reset();
        force_a5 = 1'b1;
        step(3'b010, 1'b1, 1'b0, 1'b1);
        force_a5 = 1'b0;
        check("single_early_valid", 64'(out_valid), 64'd0);
        step(3'b000, 1'b1, 1'b0, 1'b1);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_mtc", 64'(out_mtc), 64'hA5A5_A5A5_A5A5_A5A5);
        check("single_src", 64'(out_src), 64'd1);
        check("single_drops", 64'(drop_cnt), 64'd0);
        step(3'b000, 1'b1, 1'b0, 1'b1);

        // Backpressure: six pushes into input 0 while downstream stalls
        do_reset();
        held = mkdata(0, seq);
        for (int c = 0; c < 10; c++) step((c < 6) ? 3'b001 : 3'b000, 1'b0, 1'b0, 1'b1);
        check("bp_held_mtc", 64'(out_mtc), 64'(held));
        check("bp_drop0", 64'(drop_cnt[CW-1:0]), 64'd1);
        check("bp_ovf0", 64'(overflow[0]), 64'd1);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) cnt++;
            step(3'b000, 1'b1, 1'b0, 1'b1);
        end
        check("bp_kept", 64'(cnt), 64'd5);

        // Full FIFO 2 pushed and popped in the same cycle
        do_reset();
        for (int c = 0; c < 5; c++) step(3'b100, 1'b0, 1'b0, 1'b1);
        check("fullpop_pre_empty", 64'(fifo_empty), 64'b011);
        step(3'b100, 1'b1, 1'b0, 1'b1);
        check("fullpop_drop2", 64'(drop_cnt[2*CW +: CW]), 64'd0);
        check("fullpop_ovf2", 64'(overflow[2]), 64'd0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) cnt++;
            step(3'b000, 1'b1, 1'b0, 1'b1);
        end
        check("fullpop_drained", 64'(cnt), 64'd5);
        check("fullpop_empty", 64'(fifo_empty), 64'b111);

        // Drop counter saturation and clear priority
        do_reset();
        for (int c = 0; c < 5; c++) step(3'b010, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 65539; c++) step(3'b010, 1'b0, 1'b0, 1'b0);
        check("sat_cnt1", 64'(drop_cnt[CW +: CW]), 64'hFFFF);
        check("sat_ovf1", 64'(overflow[1]), 64'd1);
        compare_all();
        step(3'b010, 1'b0, 1'b1, 1'b1);
        check("clr_cnt1", 64'(drop_cnt[CW +: CW]), 64'd0);
        check("clr_ovf1", 64'(overflow[1]), 64'd0);

        // Asynchronous reset mid-stream
        do_reset();
        step(3'b111, 1'b0, 1'b0, 1'b1);
        step(3'b111, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_empty", 64'(fifo_empty), 64'b111);
        check("arst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clock);
        rst_n = 1'b1;
        model_reset();
        step(3'b000, 1'b1, 1'b0, 1'b1);
        check("arst_idle", 64'(out_valid), 64'd0);
        step(3'b111, 1'b1, 1'b0, 1'b1);
        step(3'b000, 1'b1, 1'b0, 1'b1);
        check("arst_first_valid", 64'(out_valid), 64'd1);
        check("arst_first_src", 64'(out_src), 64'd0);
        for (int c = 0; c < 3; c++) step(3'b000, 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
